// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel-clock divider and registered, mutually aligned outputs
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter bit H_POL = 1'b0,
    parameter bit V_POL = 1'b0,
    parameter int CLK_DIV = 1,
    parameter int CW = 10
) (
    input logic i_clk,
    input logic i_rst,
    input logic i_en,
    output logic pix_stb,
    output logic [CW-1:0] hp,
    output logic [CW-1:0] vp,
    output logic display,
    output logic h_sync,
    output logic v_sync,
    output logic vblank,
    output logic line_start,
    output logic frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
    localparam logic [CW-1:0] VA = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_LO = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_HI = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_LO = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_HI = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
    if (CLK_DIV < 1 || H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cfg
        $error("vga_timing_gen: CLK_DIV must be >= 1 and CW must hold H_TOTAL-1 and V_TOTAL-1");
    end
    logic [DW-1:0] div;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic tick;
    always_comb tick = i_en && div == D_LAST;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div <= '0;
            hc <= '0;
            vc <= '0;
            hp <= '0;
            vp <= '0;
            display <= 1'b0;
            vblank <= 1'b0;
            h_sync <= ~H_POL;
            v_sync <= ~V_POL;
            pix_stb <= 1'b0;
            line_start <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_stb <= tick;
            line_start <= tick && hc == '0;
            frame_start <= tick && hc == '0 && vc == '0;
            if (i_en) div <= div == D_LAST ? '0 : div + 1'b1;
            if (tick) begin
                hp <= hc;
                vp <= vc;
                display <= hc < HA && vc < VA;
                vblank <= vc >= VA;
                h_sync <= hc >= HS_LO && hc <= HS_HI ? H_POL : ~H_POL;
                v_sync <= vc >= VS_LO && vc <= VS_HI ? V_POL : ~V_POL;
                hc <= hc == H_LAST ? '0 : hc + 1'b1;
                if (hc == H_LAST) vc <= vc == V_LAST ? '0 : vc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard plus table-driven bench for three vga_timing_gen configurations
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] hp;
        logic [9:0] vp;
        logic disp, hs, vs, vb, ps, ls, fs;
    } obs_t;
    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, div;
        bit hpol, vpol;
    } fmt_t;
    typedef struct {
        int d;
        int n;
        obs_t o;
    } mst_t;
    typedef struct packed {
        logic [3:0] hp;
        logic [3:0] vp;
        logic disp, hs, vs, vb, ls, fs;
    } cexp_t;
    typedef struct {
        logic en;
        cexp_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    always #5 clk = ~clk;

    logic a_ps, a_disp, a_hs, a_vs, a_vb, a_ls, a_fs;
    logic [9:0] a_hp, a_vp;
    logic b_ps, b_disp, b_hs, b_vs, b_vb, b_ls, b_fs;
    logic [9:0] b_hp, b_vp;
    logic c_ps, c_disp, c_hs, c_vs, c_vb, c_ls, c_fs;
    logic [3:0] c_hp, c_vp;

    vga_timing_gen u_a (
        .i_clk(clk), .i_rst(rst), .i_en(en), .pix_stb(a_ps), .hp(a_hp), .vp(a_vp),
        .display(a_disp), .h_sync(a_hs), .v_sync(a_vs), .vblank(a_vb),
        .line_start(a_ls), .frame_start(a_fs)
    );
    vga_timing_gen #(.H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(3)) u_b (
        .i_clk(clk), .i_rst(rst), .i_en(en), .pix_stb(b_ps), .hp(b_hp), .vp(b_vp),
        .display(b_disp), .h_sync(b_hs), .v_sync(b_vs), .vblank(b_vb),
        .line_start(b_ls), .frame_start(b_fs)
    );
    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(4)
    ) u_c (
        .i_clk(clk), .i_rst(rst), .i_en(en), .pix_stb(c_ps), .hp(c_hp), .vp(c_vp),
        .display(c_disp), .h_sync(c_hs), .v_sync(c_vs), .vblank(c_vb),
        .line_start(c_ls), .frame_start(c_fs)
    );

    obs_t act_a, act_b, act_c;
    assign act_a = {a_hp, a_vp, a_disp, a_hs, a_vs, a_vb, a_ps, a_ls, a_fs};
    assign act_b = {b_hp, b_vp, b_disp, b_hs, b_vs, b_vb, b_ps, b_ls, b_fs};
    assign act_c = {6'd0, c_hp, 6'd0, c_vp, c_disp, c_hs, c_vs, c_vb, c_ps, c_ls, c_fs};

    int checks = 0;
    int errors = 0;
    fmt_t fa, fb, fc;
    mst_t sa, sb, sc;
    obs_t qa[$], qb[$], qc[$];
    vec_t tbl[43];
    bit mon = 1'b1;
    bit bseen = 1'b0;
    int bcnt = 0;
    int bad_gap = 0;
    int na_hs = 0;
    int nb_hs = 0;
    int prev_a_hp = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Reference derives each pixel from the number of ticks since reset.
    function automatic void mdl(input fmt_t f, input logic r, input logic e, inout mst_t s);
        int ht, vt, x, y;
        bit t;
        ht = f.ha + f.hf + f.hs + f.hb;
        vt = f.va + f.vf + f.vs + f.vb;
        if (r) begin
            s.d = 0;
            s.n = 0;
            s.o = '0;
            s.o.hs = !f.hpol;
            s.o.vs = !f.vpol;
            return;
        end
        t = e && s.d == f.div - 1;
        if (e) s.d = (s.d + 1) % f.div;
        s.o.ps = t;
        s.o.ls = 1'b0;
        s.o.fs = 1'b0;
        if (t) begin
            x = s.n % ht;
            y = (s.n / ht) % vt;
            s.n = (s.n + 1) % (ht * vt);
            s.o.hp = 10'(x);
            s.o.vp = 10'(y);
            s.o.disp = x < f.ha && y < f.va;
            s.o.vb = y >= f.va;
            s.o.hs = (x >= f.ha + f.hf && x < f.ha + f.hf + f.hs) ? f.hpol : !f.hpol;
            s.o.vs = (y >= f.va + f.vf && y < f.va + f.vf + f.vs) ? f.vpol : !f.vpol;
            s.o.ls = x == 0;
            s.o.fs = x == 0 && y == 0;
        end
    endfunction

    task automatic step(input logic r, input logic e);
        rst = r;
        en = e;
        mdl(fa, r, e, sa);
        qa.push_back(sa.o);
        mdl(fb, r, e, sb);
        qb.push_back(sb.o);
        mdl(fc, r, e, sc);
        qc.push_back(sc.o);
        @(posedge clk);
        #1;
        chk("a_outputs", act_a, qa.pop_front());
        chk("b_outputs", act_b, qb.pop_front());
        chk("c_outputs", act_c, qc.pop_front());
        if (mon) begin
            if (a_ps && a_hp == 0 && a_vp == 1) begin
                chk("a_line_wrap_prev_hp", prev_a_hp, 799);
                chk("a_line_wrap_ls", a_ls, 1);
            end
            if (a_ps) prev_a_hp = a_hp;
            if (a_ps && a_vp == 1 && !a_hs) na_hs++;
            if (b_ps && b_vp == 0 && b_hs) nb_hs++;
            if (e) bcnt++;
            if (b_ps) begin
                if (bseen && bcnt != 3) bad_gap++;
                bseen = 1'b1;
                bcnt = 0;
            end
        end
    endtask

    initial begin
        fa = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, div: 1, hpol: 1'b0, vpol: 1'b0};
        fb = fa;
        fb.hpol = 1'b1;
        fb.vpol = 1'b1;
        fb.div = 3;
        fc = '{ha: 4, hf: 1, hs: 1, hb: 1, va: 3, vf: 1, vs: 1, vb: 1, div: 1, hpol: 1'b0, vpol: 1'b0};
        for (int i = 0; i < 43; i++) begin
            int x, y;
            x = i % 7;
            y = (i / 7) % 6;
            tbl[i].en = 1'b1;
            tbl[i].exp = {4'(x), 4'(y), x < 4 && y < 3, x != 5, y != 4, y >= 3, x == 0, x == 0 && y == 0};
        end
        repeat (3) step(1'b1, 1'b1);
        chk("rst_a_hs", a_hs, 1);
        chk("rst_b_hs", b_hs, 0);
        step(1'b0, 1'b1);
        chk("start_a", {a_hp, a_vp, a_disp, a_ps, a_ls, a_fs, a_hs, a_vs}, {20'd0, 6'b111111});
        chk("start_b_no_tick", b_ps, 0);
        for (int i = 0; i < 1000 && !(a_ps && a_hp == 100); i++) step(1'b0, 1'b1);
        chk("reach_hp100", a_hp, 100);
        repeat (7) begin
            step(1'b0, 1'b0);
            chk("freeze_hp", a_hp, 100);
            chk("freeze_ps", a_ps, 0);
        end
        step(1'b0, 1'b1);
        chk("resume_hp", a_hp, 101);
        chk("resume_ps", a_ps, 1);
        repeat (2600) step(1'b0, 1'b1);
        chk("a_hsync_width", na_hs, 96);
        chk("b_hsync_width", nb_hs, 96);
        chk("b_pixel_hold", bad_gap, 0);
        mon = 1'b0;
        for (int i = 0; i < 100 && !(c_hp == 5 && c_vp == 4); i++) step(1'b0, 1'b1);
        chk("c_reach_5_4", {c_hp, c_vp}, {4'd5, 4'd4});
        step(1'b1, 1'b1);
        chk("c_mid_reset", {c_hp, c_vp, c_fs}, 9'd0);
        for (int i = 0; i < 43; i++) begin
            step(1'b0, tbl[i].en);
            chk($sformatf("c_raster_%0d", i), {c_hp, c_vp, c_disp, c_hs, c_vs, c_vb, c_ls, c_fs}, tbl[i].exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing generator. It produces pixel coordinates, active-video enable, and sync signals for any raster format, with configurable sync polarity and an internal pixel-clock divider. All outputs are mutually aligned: each describes the same pixel on the same cycle. It also provides line-start, frame-start and vertical-blank markers. It sits between the system clock and the pixel/framebuffer pipeline, feeding the VGA DAC/pins.

## Interface

Parameters:

- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync active level (0 = active-low)
- V_POL, 0, vsync active level
- CLK_DIV, 1, i_clk cycles per pixel (≥1)
- CW, 10, coordinate width; must hold H_TOTAL-1 and V_TOTAL-1, checked at elaboration with $error

Ports:

- i_clk  input  1  system clock; one clock, all logic on posedge
- i_rst  input  1  reset; synchronous, active-high
- i_en  input  1  run enable; low freezes the generator
- pix_stb  output  1  one-i_clk pulse in each cycle where outputs take a new pixel
- hp  output  CW  current pixel x
- vp  output  CW  current pixel y
- display  output  1  high when hp<H_ACTIVE and vp<V_ACTIVE
- h_sync  output  1  horizontal sync at level H_POL when active
- v_sync  output  1  vertical sync at level V_POL when active
- vblank  output  1  high when vp≥V_ACTIVE
- line_start  output  1  high with pix_stb when hp==0
- frame_start  output  1  high with pix_stb when hp==0 and vp==0

## Operation

- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider `div` counts 0..CLK_DIV-1 while i_en=1; a tick occurs when div==CLK_DIV-1 and i_en=1. When CLK_DIV=1, every enabled cycle is a tick.
- Internal counters `hc`/`vc` hold the next pixel.
  - On a tick, the registered outputs load the decode of (hc,vc), then the counters advance.
  - hc==H_TOTAL-1 → hc=0 and vc advances; otherwise hc+1.
  - vc==V_TOTAL-1 at line end → vc=0.
  - The counters never reach H_TOTAL or V_TOTAL.
- Sync windows are inclusive; a signal is inactive (~POL) outside its window:
  - h_sync=H_POL for hp in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - v_sync=V_POL for vp in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- Between ticks, every output except pix_stb, line_start and frame_start holds its value. Those three are 0 on non-tick cycles.
- i_en=0: div, counters and outputs hold; pix_stb, line_start and frame_start are 0. Resuming continues from the held position with no skipped pixel.
- Reset values: div=0, hc=0, vc=0, hp=0, vp=0, display=0, vblank=0, h_sync=~H_POL, v_sync=~V_POL, pix_stb=0, line_start=0, frame_start=0.
- Reset mid-frame: reset values apply on the next edge, and the raster restarts at (0,0). Reset has priority over i_en.

## Timing

- All outputs are registered, with no combinational path from inputs to outputs.
- First tick after reset is the edge where div reaches CLK_DIV-1 with i_en=1.
  - CLK_DIV=1: the first edge with i_rst=0 and i_en=1 presents pixel (0,0) with display=1, line_start=1, frame_start=1.
- Each pixel's outputs are held for exactly CLK_DIV enabled clocks.
- Latency: counter state to outputs is one clock, uniform for all outputs, so there is no sync-to-coordinate skew.
- Line period is H_TOTAL ticks; frame period is H_TOTAL·V_TOTAL ticks (420000 at defaults).

## Test plan

- Reset/start, defaults, i_en=1 → during reset all outputs at their reset values. First edge after release: hp=0, vp=0, display=1, pix_stb=1, line_start=1, frame_start=1, h_sync=v_sync=1.
- Line and frame wrap, defaults → hp steps 799→0 with vp 0→1 and line_start=1. At (799,524) the next pixel is (0,0) with frame_start=1. Frame period is exactly 420000 ticks.
- Sync windows, defaults →
  - h_sync=0 for hp 656..751 exactly (96 pixels per line).
  - v_sync=0 for vp 490..491 only.
  - display=0 for hp≥640 or vp≥480; vblank=1 for vp 480..524.
- Polarity and divider, H_POL=V_POL=1 and CLK_DIV=3 →
  - pix_stb fires every 3rd clock, and each hp value is held 3 clocks.
  - h_sync=1 only in hp 656..751; idle sync level is 0.
- Enable gating → drop i_en for 7 clocks at hp=100. Outputs freeze with pix_stb=0; on resume the next pixel is hp=101.
- Reset mid-frame and small format (H 4/1/1/1, V 3/1/1/1, CW=4) →
  - Assert i_rst at (5,4): the raster restarts at (0,0) with frame_start=1.
  - Verify the full 7×6 raster sequence, with h_sync asserted only at hp=5 and v_sync only at vp=4.
